// File: rtl/ncc_pkg.sv
// Shared types and constants for the NCC peak tracker: row/score widths,
// the tracker state enum and the most-negative score used to seed the search.
package ncc_pkg;
   localparam int NUM_ROWS = 16;
   localparam int ACC_W    = 32;
   localparam int SCORE_W  = ACC_W + $clog2(NUM_ROWS);

   typedef logic signed [ACC_W-1:0]   acc_t;
   typedef logic signed [SCORE_W-1:0] score_t;

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} peak_state_t;

   localparam score_t SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

   function automatic score_t sext(input acc_t v);
      return {{(SCORE_W-ACC_W){v[ACC_W-1]}}, v};
   endfunction
endpackage

// File: rtl/ncc_peak_tracker_if.sv
// Row-total input stream and result handshake of the NCC peak tracker.
// second_score exists only when NCC_PEAK_SECOND_EN is defined.
interface ncc_peak_tracker_if
   import ncc_pkg::*;
#(
   parameter int SEARCH_W = 16,
   parameter int SEARCH_H = 16
);
   localparam int XW = $clog2(SEARCH_W);
   localparam int YW = $clog2(SEARCH_H);

   logic                           start;
   logic                           row_valid;
   logic                           row_ready;
   logic [NUM_ROWS-1:0][ACC_W-1:0] row_total;
   logic                           result_valid;
   logic                           result_ready;
   score_t                         best_score;
   logic [XW-1:0]                  best_x;
   logic [YW-1:0]                  best_y;
`ifdef NCC_PEAK_SECOND_EN
   score_t                         second_score;

   modport master (output start, row_valid, row_total, result_ready,
                   input  row_ready, result_valid, best_score, best_x, best_y, second_score);
   modport slave  (input  start, row_valid, row_total, result_ready,
                   output row_ready, result_valid, best_score, best_x, best_y, second_score);
`else
   modport master (output start, row_valid, row_total, result_ready,
                   input  row_ready, result_valid, best_score, best_x, best_y);
   modport slave  (input  start, row_valid, row_total, result_ready,
                   output row_ready, result_valid, best_score, best_x, best_y);
`endif
endinterface

// File: rtl/ncc_row_sum_tree.sv
// Two-stage pipelined reduction of the per-row totals to one patch score,
// carrying the beat's valid and x/y offset alongside the data.
module ncc_row_sum_tree
   import ncc_pkg::*;
#(
   parameter int XW = 4,
   parameter int YW = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   input  logic [XW-1:0]                  in_x,
   input  logic [YW-1:0]                  in_y,
   input  logic [NUM_ROWS-1:0][ACC_W-1:0] in_rows,
   output logic                           out_valid,
   output logic [XW-1:0]                  out_x,
   output logic [YW-1:0]                  out_y,
   output score_t                         out_score
);
   localparam int GROUPS = NUM_ROWS / 4;

   score_t        part_d [GROUPS];
   score_t        part_q [GROUPS];
   score_t        total_d;
   logic          s1_valid;
   logic [XW-1:0] s1_x;
   logic [YW-1:0] s1_y;

   // Stage 1 operands: groups of four rows, widened before adding.
   always_comb begin
      for (int g = 0; g < GROUPS; g++) begin
         part_d[g] = '0;
         for (int r = 0; r < 4; r++) begin
            part_d[g] = part_d[g] + sext(acc_t'(in_rows[g*4+r]));
         end
      end
   end

   always_comb begin
      total_d = '0;
      for (int g = 0; g < GROUPS; g++) begin
         total_d = total_d + part_q[g];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_y     <= '0;
         for (int g = 0; g < GROUPS; g++) part_q[g] <= '0;
      end else begin
         s1_valid <= in_valid;
         s1_x     <= in_x;
         s1_y     <= in_y;
         for (int g = 0; g < GROUPS; g++) part_q[g] <= part_d[g];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_x     <= '0;
         out_y     <= '0;
         out_score <= '0;
      end else begin
         out_valid <= s1_valid;
         out_x     <= s1_x;
         out_y     <= s1_y;
         out_score <= total_d;
      end
   end
endmodule

// File: rtl/ncc_peak_tracker.sv
// Raster-scan peak tracker: sums row totals per window position and keeps the
// earliest maximum score. Define NCC_PEAK_SECOND_EN to also track the runner-up.
module ncc_peak_tracker
   import ncc_pkg::*;
#(
   parameter int SEARCH_W = 16,
   parameter int SEARCH_H = 16
) (
   input logic              clk,
   input logic              rst,
   ncc_peak_tracker_if.slave bus
);
   localparam int XW = $clog2(SEARCH_W);
   localparam int YW = $clog2(SEARCH_H);
   localparam logic [XW-1:0] X_LAST = XW'(SEARCH_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(SEARCH_H - 1);

   peak_state_t   state;
   logic [XW-1:0] x_cnt;
   logic [YW-1:0] y_cnt;
   logic          drain_cnt;
   logic          result_valid_q;
   logic          accept;

   logic          sum_valid;
   logic [XW-1:0] sum_x;
   logic [YW-1:0] sum_y;
   score_t        sum_score;

   score_t        best_q;
   logic [XW-1:0] best_x_q;
   logic [YW-1:0] best_y_q;

   assign bus.row_ready    = (state == SCAN);
   assign accept           = bus.row_valid && (state == SCAN);
   assign bus.result_valid = result_valid_q;
   assign bus.best_score   = best_q;
   assign bus.best_x       = best_x_q;
   assign bus.best_y       = best_y_q;

   ncc_row_sum_tree #(.XW(XW), .YW(YW)) u_tree (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (accept),
      .in_x      (x_cnt),
      .in_y      (y_cnt),
      .in_rows   (bus.row_total),
      .out_valid (sum_valid),
      .out_x     (sum_x),
      .out_y     (sum_y),
      .out_score (sum_score)
   );

   // DRAIN lasts exactly the tree latency so the final compare lands as DONE begins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         x_cnt          <= '0;
         y_cnt          <= '0;
         drain_cnt      <= 1'b0;
         result_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state <= SCAN;
                  x_cnt <= '0;
                  y_cnt <= '0;
               end
            end
            SCAN: begin
               if (accept) begin
                  if (x_cnt == X_LAST) begin
                     x_cnt <= '0;
                     if (y_cnt == Y_LAST) begin
                        y_cnt     <= '0;
                        drain_cnt <= 1'b0;
                        state     <= DRAIN;
                     end else begin
                        y_cnt <= y_cnt + 1'b1;
                     end
                  end else begin
                     x_cnt <= x_cnt + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (drain_cnt) begin
                  state          <= DONE;
                  result_valid_q <= 1'b1;
               end else begin
                  drain_cnt <= 1'b1;
               end
            end
            DONE: begin
               if (bus.result_ready) begin
                  state          <= IDLE;
                  result_valid_q <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef NCC_PEAK_SECOND_EN
   score_t second_q;
   assign bus.second_score = second_q;
`endif

   // Strictly-greater replacement keeps the earliest position on ties.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         best_q   <= '0;
         best_x_q <= '0;
         best_y_q <= '0;
`ifdef NCC_PEAK_SECOND_EN
         second_q <= '0;
`endif
      end else if (state == IDLE && bus.start) begin
         best_q   <= SCORE_MIN;
         best_x_q <= '0;
         best_y_q <= '0;
`ifdef NCC_PEAK_SECOND_EN
         second_q <= SCORE_MIN;
`endif
      end else if (sum_valid) begin
         if (sum_score > best_q) begin
            best_q   <= sum_score;
            best_x_q <= sum_x;
            best_y_q <= sum_y;
`ifdef NCC_PEAK_SECOND_EN
            second_q <= best_q;
         end else if (sum_score > second_q) begin
            second_q <= sum_score;
`endif
         end
      end
   end
endmodule

// File: tb/tb_ncc_peak_tracker.sv
// Randomised self-checking bench for ncc_peak_tracker on a 4x4 search, compared
// against a whole-scan reference model of the scores.
module tb_ncc_peak_tracker;
   import ncc_pkg::*;

   localparam int SW   = 4;
   localparam int SH   = 4;
   localparam int NPOS = SW * SH;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ncc_peak_tracker_if #(.SEARCH_W(SW), .SEARCH_H(SH)) bus ();

   ncc_peak_tracker #(.SEARCH_W(SW), .SEARCH_H(SH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   logic signed [31:0] rows [NPOS][NUM_ROWS];

   longint obs_score;
   longint obs_second;
   int     obs_x;
   int     obs_y;
   bit     obs_stable;
   bit     obs_timeout;

   // Reference model: scores computed from whole positions, then reduced.
   function automatic longint pos_score(input int p);
      longint s = 0;
      for (int r = 0; r < NUM_ROWS; r++) s += longint'(rows[p][r]);
      return s;
   endfunction

   function automatic void model_best(output longint s, output int x, output int y);
      int bp = 0;
      s = pos_score(0);
      for (int p = 1; p < NPOS; p++) begin
         if (pos_score(p) > s) begin
            s  = pos_score(p);
            bp = p;
         end
      end
      x = bp % SW;
      y = bp / SW;
   endfunction

   function automatic longint model_second();
      longint q[$];
      for (int p = 0; p < NPOS; p++) q.push_back(pos_score(p));
      q.rsort();
      return q[1];
   endfunction

   task automatic fill_all(input int v);
      for (int p = 0; p < NPOS; p++)
         for (int r = 0; r < NUM_ROWS; r++) rows[p][r] = v;
   endtask

   task automatic fill_random();
      for (int p = 0; p < NPOS; p++)
         for (int r = 0; r < NUM_ROWS; r++) rows[p][r] = $urandom;
   endtask

   task automatic run_scan(input int bubble_pct, input int hold, input int start_pulse_at);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int p = 0; p < NPOS; p++) begin
         while (bubble_pct > 0 && $urandom_range(99) < bubble_pct) begin
            bus.row_valid = 1'b0;
            @(posedge clk); #1;
         end
         bus.row_valid = 1'b1;
         for (int r = 0; r < NUM_ROWS; r++) bus.row_total[r] = rows[p][r];
         if (p == start_pulse_at) bus.start = 1'b1;
         @(posedge clk); #1;
         bus.start = 1'b0;
      end
      bus.row_valid = 1'b0;
      bus.row_total = '0;
      obs_timeout = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (bus.result_valid) begin
            obs_timeout = 1'b0;
            break;
         end
         @(posedge clk); #1;
      end
      obs_score  = longint'(bus.best_score);
      obs_x      = int'(bus.best_x);
      obs_y      = int'(bus.best_y);
`ifdef NCC_PEAK_SECOND_EN
      obs_second = longint'(bus.second_score);
`else
      obs_second = 0;
`endif
      obs_stable = 1'b1;
      repeat (hold) begin
         @(posedge clk); #1;
         if (!bus.result_valid || longint'(bus.best_score) != obs_score ||
             int'(bus.best_x) != obs_x || int'(bus.best_y) != obs_y)
            obs_stable = 1'b0;
      end
      bus.result_ready = 1'b1;
      @(posedge clk); #1;
      bus.result_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.row_ready !== 1'b0 || bus.result_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl ready=%b valid=%b expected 0 0", bus.row_ready, bus.result_valid);
      end
      checks++;
      if (bus.best_score !== '0 || bus.best_x !== '0 || bus.best_y !== '0) begin
         errors++;
         $display("[TB] FAIL reset_best got %0d (%0d,%0d) expected 0 (0,0)", bus.best_score, bus.best_x, bus.best_y);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_idle_ignore();
      bus.row_valid = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         checks++;
         if (bus.row_ready !== 1'b0 || bus.result_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_ignore ready=%b valid=%b expected 0 0", bus.row_ready, bus.result_valid);
         end
      end
      bus.row_valid = 1'b0;
   endtask

   task automatic test_single_peak();
      longint es; int ex, ey;
      fill_all(0);
      for (int r = 0; r < NUM_ROWS; r++) rows[1*SW+2][r] = 5;
      model_best(es, ex, ey);
      run_scan(0, 0, -1);
      checks++;
      if (obs_timeout || obs_score != es || obs_x != ex || obs_y != ey) begin
         errors++;
         $display("[TB] FAIL single_peak got %0d (%0d,%0d) to=%0b expected %0d (%0d,%0d)", obs_score, obs_x, obs_y, obs_timeout, es, ex, ey);
      end
   endtask

   task automatic test_tie();
      longint es; int ex, ey;
      fill_all(1);
      model_best(es, ex, ey);
      run_scan(0, 0, -1);
      checks++;
      if (obs_timeout || obs_score != es || obs_x != ex || obs_y != ey) begin
         errors++;
         $display("[TB] FAIL tie got %0d (%0d,%0d) expected %0d (%0d,%0d)", obs_score, obs_x, obs_y, es, ex, ey);
      end
   endtask

   task automatic test_negative();
      longint es; int ex, ey;
      fill_all(-1);
      for (int r = 0; r < NUM_ROWS; r++) rows[3*SW+3][r] = -2;
      model_best(es, ex, ey);
      run_scan(0, 0, -1);
      checks++;
      if (obs_timeout || obs_score != es || obs_x != ex || obs_y != ey) begin
         errors++;
         $display("[TB] FAIL negative got %0d (%0d,%0d) expected %0d (%0d,%0d)", obs_score, obs_x, obs_y, es, ex, ey);
      end
   endtask

   task automatic test_bubbles_backpressure();
      longint es; int ex, ey;
      fill_random();
      model_best(es, ex, ey);
      run_scan(40, 5, 5);
      checks++;
      if (obs_timeout || obs_score != es || obs_x != ex || obs_y != ey) begin
         errors++;
         $display("[TB] FAIL bubbles got %0d (%0d,%0d) expected %0d (%0d,%0d)", obs_score, obs_x, obs_y, es, ex, ey);
      end
      checks++;
      if (!obs_stable) begin
         errors++;
         $display("[TB] FAIL hold_stable got unstable expected stable");
      end
      repeat (3) begin
         checks++;
         if (bus.result_valid !== 1'b0 || bus.row_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_handshake valid=%b ready=%b expected 0 0", bus.result_valid, bus.row_ready);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_midscan();
      longint es; int ex, ey;
      fill_random();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int p = 0; p < 7; p++) begin
         bus.row_valid = 1'b1;
         for (int r = 0; r < NUM_ROWS; r++) bus.row_total[r] = rows[p][r];
         @(posedge clk); #1;
      end
      bus.row_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.row_ready !== 1'b0 || bus.result_valid !== 1'b0 || bus.best_score !== '0) begin
         errors++;
         $display("[TB] FAIL midscan_reset ready=%b valid=%b best=%0d expected 0 0 0", bus.row_ready, bus.result_valid, bus.best_score);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      fill_all(0);
      rows[2*SW+1][0] = 100;
      model_best(es, ex, ey);
      run_scan(0, 0, -1);
      checks++;
      if (obs_timeout || obs_score != es || obs_x != ex || obs_y != ey) begin
         errors++;
         $display("[TB] FAIL rescan got %0d (%0d,%0d) expected %0d (%0d,%0d)", obs_score, obs_x, obs_y, es, ex, ey);
      end
   endtask

   task automatic test_random();
      longint es; int ex, ey;
      for (int n = 0; n < 4; n++) begin
         fill_random();
         model_best(es, ex, ey);
         run_scan(20, $urandom_range(3), -1);
         checks++;
         if (obs_timeout || obs_score != es || obs_x != ex || obs_y != ey) begin
            errors++;
            $display("[TB] FAIL random%0d got %0d (%0d,%0d) expected %0d (%0d,%0d)", n, obs_score, obs_x, obs_y, es, ex, ey);
         end
`ifdef NCC_PEAK_SECOND_EN
         checks++;
         if (obs_second != model_second()) begin
            errors++;
            $display("[TB] FAIL random_second%0d got %0d expected %0d", n, obs_second, model_second());
         end
`endif
      end
   endtask

`ifdef NCC_PEAK_SECOND_EN
   task automatic test_second();
      longint es; int ex, ey;
      fill_all(0);
      for (int p = 3; p < NPOS; p++) rows[p][0] = -5;
      rows[0][0] = 10;
      rows[1][0] = 30;
      rows[2][0] = 20;
      model_best(es, ex, ey);
      run_scan(0, 0, -1);
      checks++;
      if (obs_timeout || obs_score != es || obs_second != model_second()) begin
         errors++;
         $display("[TB] FAIL second got %0d/%0d expected %0d/%0d", obs_score, obs_second, es, model_second());
      end
   endtask
`endif

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bus.start        = 1'b0;
      bus.row_valid    = 1'b0;
      bus.row_total    = '0;
      bus.result_ready = 1'b0;
      test_reset();
      test_idle_ignore();
      test_single_peak();
      test_tie();
      test_negative();
      test_bubbles_backpressure();
      test_reset_midscan();
      test_random();
`ifdef NCC_PEAK_SECOND_EN
      test_second();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
